cve2_ex_seq_ctrl: RTL and testbench
===================================

// Module: cve2_ex_seq_ctrl
// PURPOSE
//  Sequences the EX stage (ALU + MUL/DIV) for one operation at a time. Accepts ops from ID over
//  a valid/ready handshake and drives the ALU first-cycle flag and the mult/div enable/select
//  strobes. Owns the two 34-bit intermediate-value registers, registers the result behind a
//  response handshake, and aborts on flush or on a stuck-op watchdog.
// PARAMETERS
//  RV32M          cve2_pkg::RV32MFast  M-extension config; RV32MNone makes MULT/DIV ops error out.
//  TimeoutCycles  int 64               max EXEC cycles without ex_valid_i before abort (>=2).
// PORTS
//  clk_i              in   1      clock
//  rst_i              in   1      asynchronous reset, active-high
//  req_valid_i        in   1      ID presents an op
//  req_ready_o        out  1      controller accepts the op this cycle
//  req_kind_i         in   2      0=ALU 1=MULT 2=DIV 3=reserved
//  flush_i            in   1      kill in-flight op/response
//  alu_instr_first_cycle_o out 1  first EXEC cycle of current op
//  mult_en_o, div_en_o     out 1  dynamic FSM enables to multdiv
//  mult_sel_o, div_sel_o   out 1  static data-mux selects
//  imd_val_we_i       in   2      per-register write enables from EX
//  imd_val_d_i        in   34x2   write data from EX
//  imd_val_q_o        out  34x2   intermediate register contents to EX
//  ex_valid_i         in   1      EX result valid this cycle
//  result_i           in   32     EX result
//  rsp_valid_o        out  1      registered result available
//  rsp_ready_i        in   1      writeback consumes result
//  rsp_result_o       out  32     registered result
//  rsp_err_o          out  1      response is an error (unsupported/reserved kind), result=0
//  busy_o             out  1      state != IDLE
//  timeout_o          out  1      one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset (async, rst_i=1): state=IDLE; all outputs 0 except req_ready_o=1; imd regs, counter,
//   latched kind, rsp_result_o cleared.
//  FSM IDLE/EXEC/HOLD. req_ready_o = ~flush_i & (IDLE | (HOLD & rsp_ready_i)).
//  Accept (req_valid_i & req_ready_o): latch kind. Supported kind -> EXEC, cycle counter=0.
//   kind 3, or kind 1/2 with RV32M==RV32MNone -> HOLD directly, rsp_err_o=1, result 0.
//  EXEC: mult_sel_o=(kind==1), div_sel_o=(kind==2), held for whole EXEC;
//   mult_en_o=mult_sel_o&~flush_i, div_en_o=div_sel_o&~flush_i (combinational);
//   alu_instr_first_cycle_o=1 only on first EXEC cycle. imd_val_q[i]<=imd_val_d_i[i] when
//   imd_val_we_i[i]. On ex_valid_i: rsp_result_o<=result_i, rsp_err_o<=0, -> HOLD.
//  Selects/enables are 0 outside EXEC; imd_val_we_i ignored outside EXEC.
//  HOLD: rsp_valid_o=1; result stable until rsp_ready_i. rsp_ready_i & req_valid_i same cycle ->
//   back-to-back accept straight into EXEC/HOLD; rsp_ready_i alone -> IDLE.
//  Latency: single-cycle ALU op accepted cycle N -> EXEC N+1 -> rsp_valid_o at N+2.
//  Watchdog: counter increments each EXEC cycle without ex_valid_i; reaching TimeoutCycles-1
//   -> timeout_o pulse next cycle, imd regs cleared, -> IDLE, no response. ex_valid_i in that
//   same cycle wins (normal completion, no timeout).
//  flush_i (any state): next state IDLE, rsp_valid_o drops next cycle, imd regs cleared, no
//   accept that cycle; flush has priority over ex_valid_i and timeout.
//  Counter saturates; never wraps.
// TESTING
//  ALU op kind0, ex_valid_i in 1st EXEC cycle, result_i=0x1234 -> rsp_valid_o at N+2, result
//   0x1234, first_cycle pulse exactly once, mult/div sel 0.
//  DIV op, ex_valid_i after 34 cycles with imd_we=2'b11, d=34'h3_0000_0001 -> imd_val_q_o
//   tracks, div_sel_o held 34 cycles, rsp after completion.
//  Hold rsp_ready_i=0 5 cycles with new req_valid_i -> req_ready_o=0, result stable; release ->
//   back-to-back accept same cycle.
//  flush_i mid-MULT (cycle 3) -> mult_en_o=0 that cycle, IDLE next, imd regs 0, no rsp.
//  TimeoutCycles=8, never ex_valid_i -> timeout_o pulse after 8 EXEC cycles, busy_o=0 after.
//  RV32M=RV32MNone MULT, and kind 3 -> rsp_err_o=1, rsp_result_o=0, N+1; async rst_i mid-EXEC
//   -> all outputs reset immediately.

Source files
------------

// File: rtl/cve2_ex_seq_ctrl.sv
// EX-stage sequencing controller: one ALU/MUL/DIV op at a time, intermediate-value
// registers, registered response handshake, flush and stuck-op watchdog abort.

package cve2_pkg;
    typedef enum integer {
        RV32MNone        = 0,
        RV32MSlow        = 1,
        RV32MFast        = 2,
        RV32MSingleCycle = 3
    } rv32m_e;
endpackage

module cve2_ex_seq_ctrl
    import cve2_pkg::*;
#(
    parameter rv32m_e RV32M         = RV32MFast,
    parameter int     TimeoutCycles = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_kind_i,
    input  logic        flush_i,
    output logic        alu_instr_first_cycle_o,
    output logic        mult_en_o,
    output logic        div_en_o,
    output logic        mult_sel_o,
    output logic        div_sel_o,
    input  logic [1:0]  imd_val_we_i,
    input  logic [33:0] imd_val_d_i [2],
    output logic [33:0] imd_val_q_o [2],
    input  logic        ex_valid_i,
    input  logic [31:0] result_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic        timeout_o
);
    // state | meaning
    // IDLE  | nothing in flight, ready for a new op
    // EXEC  | op issued to ALU/multdiv, waiting for ex_valid_i
    // HOLD  | result or error registered, waiting for writeback
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

    localparam int              CntW    = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    state_e          state_q;
    logic [1:0]      kind_q;
    logic [CntW-1:0] cnt_q;
    logic            first_q;
    logic            timeout_q;
    logic            rsp_err_q;
    logic [31:0]     rsp_result_q;

    logic in_exec;
    logic accept;
    logic kind_unsup;
    logic exec_abort;

    always_comb begin
        in_exec     = (state_q == EXEC);
        req_ready_o = ~flush_i & ((state_q == IDLE) | ((state_q == HOLD) & rsp_ready_i));
        accept      = req_valid_i & req_ready_o;
        // Without the M extension only ALU ops are executable.
        kind_unsup  = (req_kind_i == 2'd3) |
                      ((RV32M == RV32MNone) & (req_kind_i != 2'd0));
        exec_abort  = in_exec & ~ex_valid_i & (cnt_q == CntLast);
    end

    assign mult_sel_o              = in_exec & (kind_q == 2'd1);
    assign div_sel_o               = in_exec & (kind_q == 2'd2);
    assign mult_en_o               = mult_sel_o & ~flush_i;
    assign div_en_o                = div_sel_o & ~flush_i;
    assign alu_instr_first_cycle_o = first_q;
    assign rsp_valid_o             = (state_q == HOLD);
    assign rsp_result_o            = rsp_result_q;
    assign rsp_err_o               = rsp_err_q;
    assign busy_o                  = (state_q != IDLE);
    assign timeout_o               = timeout_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            kind_q       <= '0;
            cnt_q        <= '0;
            first_q      <= 1'b0;
            timeout_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
            for (int i = 0; i < 2; i++) imd_val_q_o[i] <= '0;
        end else begin
            first_q   <= 1'b0;
            timeout_q <= 1'b0;
            if (flush_i) begin
                state_q <= IDLE;
                for (int i = 0; i < 2; i++) imd_val_q_o[i] <= '0;
            end else if (accept) begin
                kind_q <= req_kind_i;
                cnt_q  <= '0;
                if (kind_unsup) begin
                    state_q      <= HOLD;
                    rsp_result_q <= '0;
                    rsp_err_q    <= 1'b1;
                end else begin
                    state_q <= EXEC;
                    first_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    EXEC: begin
                        for (int i = 0; i < 2; i++) begin
                            if (imd_val_we_i[i]) imd_val_q_o[i] <= imd_val_d_i[i];
                        end
                        // Completion in the watchdog's last cycle still counts as completion.
                        if (ex_valid_i) begin
                            rsp_result_q <= result_i;
                            rsp_err_q    <= 1'b0;
                            state_q      <= HOLD;
                        end else if (exec_abort) begin
                            timeout_q <= 1'b1;
                            state_q   <= IDLE;
                            for (int i = 0; i < 2; i++) imd_val_q_o[i] <= '0;
                        end else if (cnt_q != CntLast) begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    HOLD: begin
                        if (rsp_ready_i) state_q <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cve2_ex_seq_ctrl.sv
// Bench for cve2_ex_seq_ctrl: random ops scored against a queue of expected outcomes,
// plus directed hold, flush, watchdog, no-M-extension and async-reset scenarios.
module tb_cve2_ex_seq_ctrl;
    import cve2_pkg::*;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, flush;
    logic [1:0]  req_kind;
    logic        first, mult_en, div_en, mult_sel, div_sel;
    logic [1:0]  imd_we;
    logic [33:0] imd_d [2];
    logic [33:0] imd_q [2];
    logic        ex_valid, rsp_valid, rsp_ready, rsp_err, busy, timeout;
    logic [31:0] result, rsp_result;

    logic        n_req_valid, n_req_ready, n_ex_valid, n_rsp_ready;
    logic [1:0]  n_req_kind;
    logic        n_first, n_mult_en, n_div_en, n_mult_sel, n_div_sel;
    logic [33:0] n_imd_q [2];
    logic        n_rsp_valid, n_rsp_err, n_busy, n_timeout;
    logic [31:0] n_rsp_result;

    cve2_ex_seq_ctrl #(.RV32M(RV32MFast), .TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_kind_i(req_kind), .flush_i(flush), .alu_instr_first_cycle_o(first),
        .mult_en_o(mult_en), .div_en_o(div_en), .mult_sel_o(mult_sel), .div_sel_o(div_sel),
        .imd_val_we_i(imd_we), .imd_val_d_i(imd_d), .imd_val_q_o(imd_q),
        .ex_valid_i(ex_valid), .result_i(result), .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result), .rsp_err_o(rsp_err),
        .busy_o(busy), .timeout_o(timeout)
    );

    cve2_ex_seq_ctrl #(.RV32M(RV32MNone), .TimeoutCycles(8)) dut_n (
        .clk_i(clk), .rst_i(rst), .req_valid_i(n_req_valid), .req_ready_o(n_req_ready),
        .req_kind_i(n_req_kind), .flush_i(flush), .alu_instr_first_cycle_o(n_first),
        .mult_en_o(n_mult_en), .div_en_o(n_div_en), .mult_sel_o(n_mult_sel), .div_sel_o(n_div_sel),
        .imd_val_we_i(imd_we), .imd_val_d_i(imd_d), .imd_val_q_o(n_imd_q),
        .ex_valid_i(n_ex_valid), .result_i(result), .rsp_valid_o(n_rsp_valid),
        .rsp_ready_i(n_rsp_ready), .rsp_result_o(n_rsp_result), .rsp_err_o(n_rsp_err),
        .busy_o(n_busy), .timeout_o(n_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Expected outcome of one accepted op: a response (err/result) or a watchdog abort.
    typedef struct packed {
        logic        to;
        logic        err;
        logic [31:0] res;
    } exp_t;

    exp_t        sbq[$];
    bit          mon_en  = 1'b1;
    bit          rr_rand = 1'b1;
    logic [33:0] m_imd [2];

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && !rst && ((rsp_valid && rsp_ready) || timeout)) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got rsp_valid=%0b timeout=%0b, expected nothing", rsp_valid, timeout);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_is_timeout", timeout, e.to);
                    if (!e.to) begin
                        chk("sb_rsp_err", rsp_err, e.err);
                        chk("sb_rsp_result", rsp_result, e.res);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        ex_valid  = 1'b0;
        if (rr_rand) rsp_ready = 1'($urandom_range(0, 1));
        imd_we    = 2'($urandom_range(0, 3));
        imd_d[0]  = {2'($urandom_range(0, 3)), 32'($urandom)};
        imd_d[1]  = {2'($urandom_range(0, 3)), 32'($urandom)};
    endtask

    // Issue one op; lat = index of the EXEC cycle carrying ex_valid (>= TO means never).
    task automatic run_op(input logic [1:0] k, input int lat, input logic [31:0] res, input bit fixed);
        bit   acc = 1'b0;
        exp_t e;
        req_valid = 1'b1;
        req_kind  = k;
        for (int c = 0; c < 200 && !acc; c++) begin
            #1;
            if (req_ready) acc = 1'b1;
            else tick();
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no req_ready within 200 cycles, expected accept");
            req_valid = 1'b0;
            return;
        end
        e.to  = (k != 2'd3) && (lat >= TO);
        e.err = (k == 2'd3);
        e.res = (k == 2'd3 || lat >= TO) ? 32'h0 : res;
        sbq.push_back(e);
        tick();
        req_valid = 1'b0;
        if (k == 2'd3) begin
            #1;
            chk("err_rsp_at_n1", rsp_valid, 1'b1);
            return;
        end
        for (int idx = 0; idx < TO; idx++) begin
            if (fixed) begin
                imd_we   = 2'b11;
                imd_d[0] = 34'h3_0000_0001;
                imd_d[1] = 34'h3_0000_0001;
            end
            ex_valid = (idx == lat);
            result   = res;
            #1;
            chk("exec_first_cycle", first, (idx == 0));
            chk("exec_mult_sel", mult_sel, (k == 2'd1));
            chk("exec_div_sel", div_sel, (k == 2'd2));
            chk("exec_mult_en", mult_en, (k == 2'd1));
            chk("exec_div_en", div_en, (k == 2'd2));
            chk("exec_busy", busy, 1'b1);
            chk("exec_rsp_valid", rsp_valid, 1'b0);
            chk("exec_req_ready", req_ready, 1'b0);
            chk("exec_imd0", imd_q[0], m_imd[0]);
            chk("exec_imd1", imd_q[1], m_imd[1]);
            for (int i = 0; i < 2; i++) if (imd_we[i]) m_imd[i] = imd_d[i];
            if (idx == lat || idx == TO - 1) break;
            tick();
        end
        if (lat >= TO) begin
            m_imd[0] = '0;
            m_imd[1] = '0;
        end
        tick();
        #1;
        if (lat < TO) chk("rsp_valid_after_done", rsp_valid, 1'b1);
        else chk("idle_after_timeout", busy, 1'b0);
    endtask

    initial begin
        logic [33:0] snap;
        req_valid = 0; req_kind = 0; flush = 0; imd_we = 0; ex_valid = 0; result = 0;
        rsp_ready = 0; imd_d[0] = 0; imd_d[1] = 0;
        n_req_valid = 0; n_req_kind = 0; n_ex_valid = 0; n_rsp_ready = 0;
        m_imd[0] = 0; m_imd[1] = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_first", first, 1'b0);
        chk("rst_sels", {mult_sel, div_sel, mult_en, div_en}, 4'b0);
        chk("rst_imd0", imd_q[0], 34'h0);
        chk("rst_imd1", imd_q[1], 34'h0);
        rst = 1'b0;
        tick();

        run_op(2'd0, 0, 32'h1234, 1'b0);
        run_op(2'd2, 33, 32'h0BAD_D1D0, 1'b1);
        run_op(2'd1, TO + 3, 32'h0, 1'b0);
        repeat (60) begin
            logic [1:0] k;
            int         lat;
            k   = 2'($urandom_range(0, 3));
            lat = ($urandom_range(0, 9) == 0) ? TO + 5 : int'($urandom_range(0, 8));
            run_op(k, lat, 32'($urandom), 1'b0);
        end
        for (int c = 0; c < 100 && sbq.size() != 0; c++) tick();
        chk("sb_drained", sbq.size(), 0);

        mon_en    = 1'b0;
        rr_rand   = 1'b0;
        rsp_ready = 1'b1;
        tick();
        tick();
        #1;
        chk("dir_idle", busy, 1'b0);

        // Result held while writeback stalls, then back-to-back accept.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_kind  = 2'd0;
        tick();
        req_valid = 1'b0;
        ex_valid  = 1'b1;
        result    = 32'hCAFE_0001;
        tick();
        #1;
        chk("hold_rsp_valid", rsp_valid, 1'b1);
        req_valid = 1'b1;
        req_kind  = 2'd2;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("hold_req_ready", req_ready, 1'b0);
            chk("hold_result_stable", rsp_result, 32'hCAFE_0001);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("b2b_req_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_rsp_valid", rsp_valid, 1'b0);
        chk("b2b_div_sel", div_sel, 1'b1);
        chk("b2b_first", first, 1'b1);
        ex_valid = 1'b1;
        result   = 32'h5;
        tick();
        tick();

        // Flush in the fourth EXEC cycle of a MULT.
        req_valid = 1'b1;
        req_kind  = 2'd1;
        tick();
        req_valid = 1'b0;
        imd_we    = 2'b11;
        imd_d[0]  = 34'h2_1234_5678;
        imd_d[1]  = 34'h1_8765_4321;
        #1;
        chk("flush_pre_mult_en", mult_en, 1'b1);
        tick();
        imd_we = 2'b00;
        tick();
        imd_we = 2'b00;
        tick();
        imd_we = 2'b00;
        flush  = 1'b1;
        #1;
        chk("flush_mult_en", mult_en, 1'b0);
        chk("flush_imd0_before", imd_q[0], 34'h2_1234_5678);
        chk("flush_req_ready", req_ready, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_busy", busy, 1'b0);
        chk("flush_mult_sel", mult_sel, 1'b0);
        chk("flush_rsp_valid", rsp_valid, 1'b0);
        chk("flush_imd0", imd_q[0], 34'h0);
        chk("flush_imd1", imd_q[1], 34'h0);

        // No-M instance: ALU works, then MULT and kind 3 error out at N+1.
        n_rsp_ready = 1'b0;
        n_req_valid = 1'b1;
        n_req_kind  = 2'd0;
        tick();
        n_req_valid = 1'b0;
        n_ex_valid  = 1'b1;
        result      = 32'hABCD;
        tick();
        n_ex_valid = 1'b0;
        #1;
        chk("nom_alu_result", n_rsp_result, 32'hABCD);
        for (int j = 0; j < 2; j++) begin
            n_rsp_ready = 1'b1;
            n_req_valid = 1'b1;
            n_req_kind  = (j == 0) ? 2'd1 : 2'd3;
            tick();
            n_req_valid = 1'b0;
            n_rsp_ready = 1'b0;
            #1;
            chk("nom_err_valid", n_rsp_valid, 1'b1);
            chk("nom_err_flag", n_rsp_err, 1'b1);
            chk("nom_err_result", n_rsp_result, 32'h0);
            chk("nom_err_mult_sel", n_mult_sel, 1'b0);
        end
        n_rsp_ready = 1'b1;
        tick();
        n_rsp_ready = 1'b0;

        // Watchdog on the 8-cycle instance.
        n_req_valid = 1'b1;
        n_req_kind  = 2'd0;
        tick();
        n_req_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("wd_busy", n_busy, 1'b1);
            chk("wd_no_pulse", n_timeout, 1'b0);
            tick();
        end
        #1;
        chk("wd_pulse", n_timeout, 1'b1);
        chk("wd_busy_after", n_busy, 1'b0);
        chk("wd_no_rsp", n_rsp_valid, 1'b0);
        tick();
        #1;
        chk("wd_pulse_one_cycle", n_timeout, 1'b0);

        // Asynchronous reset in the middle of a DIV.
        req_valid = 1'b1;
        req_kind  = 2'd2;
        tick();
        req_valid = 1'b0;
        imd_we    = 2'b01;
        imd_d[0]  = 34'h3_0000_00AA;
        tick();
        imd_we = 2'b00;
        #1;
        snap = imd_q[0];
        chk("arst_imd_before", snap, 34'h3_0000_00AA);
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_div_sel", div_sel, 1'b0);
        chk("arst_div_en", div_en, 1'b0);
        chk("arst_imd0", imd_q[0], 34'h0);
        chk("arst_req_ready", req_ready, 1'b1);
        chk("arst_rsp_result", rsp_result, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got no completion, expected finish before limit");
        $fatal(1);
    end

endmodule
